// File: rtl/data_router_lb.sv
// Line-buffer router feeding the PE array.
//
// Holds POY banks x BUFH rows x BUFW words. Rows are loaded whole through a valid/ready
// write port. Read commands (RR, BR, RP, BC) are served through a one-stage registered
// output with backpressure. Only the words selected by a command are updated; every
// other output word keeps its previous value.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   wr_valid/wr_ready   write handshake; wr_ready is 1 whenever rst is low
//   wr_bank/wr_row      target row of the write
//   wr_data             full row, word k = bits [k*DW +: DW]
//   cmd_valid/cmd_ready command handshake; cmd_ready = !out_valid || out_ready
//   cmd_mode            00 RR, 01 BR, 10 RP, 11 BC
//   cmd_bank/row/col    command operands
//   cmd_last            last command of a block
//   out_data/out_mask   registered result; bank i word k = bits [(i*BUFW+k)*DW +: DW]
//   out_valid/out_ready result handshake
//   blkend              one-cycle pulse aligned with the first cycle of a block's last result
//   blk_cnt             completed blocks, wraps at 2^16
//   err                 sticky illegal write/command flag
module data_router_lb #(
  parameter int unsigned DW   = 32,
  parameter int unsigned POY  = 3,
  parameter int unsigned BUFW = 32,
  parameter int unsigned BUFH = 3,
  parameter int unsigned BW   = (POY > 1) ? $clog2(POY) : 1,
  parameter int unsigned RW   = (BUFH > 1) ? $clog2(BUFH) : 1,
  parameter int unsigned CW   = (BUFW > 1) ? $clog2(BUFW) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [BW-1:0]            wr_bank,
  input  logic [RW-1:0]            wr_row,
  input  logic [BUFW*DW-1:0]       wr_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [BW-1:0]            cmd_bank,
  input  logic [RW-1:0]            cmd_row,
  input  logic [CW-1:0]            cmd_col,
  input  logic                     cmd_last,
  output logic [POY*BUFW*DW-1:0]   out_data,
  output logic [POY*BUFW-1:0]      out_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     blkend,
  output logic [15:0]              blk_cnt,
  output logic                     err
);

  localparam int unsigned RowW  = BUFW * DW;
  localparam int unsigned OutW  = POY * BUFW * DW;
  localparam int unsigned MaskW = POY * BUFW;

  localparam logic [1:0] ModeRr = 2'b00;
  localparam logic [1:0] ModeBr = 2'b01;
  localparam logic [1:0] ModeRp = 2'b10;
  localparam logic [1:0] ModeBc = 2'b11;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [OutW-1:0]   out_data_q, out_data_d;
  logic [MaskW-1:0]  out_mask_q, out_mask_d;
  logic              blkend_q, blkend_d;
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic              err_q, err_d;

  // Line buffer storage; contents are deliberately not reset.
  logic [RowW-1:0]   mem_q [POY][BUFH];

  logic              wr_fire, wr_legal;
  logic              cmd_fire, cmd_legal, bank_sel;
  logic [OutW-1:0]   res_data;
  logic [MaskW-1:0]  res_mask;
  logic [RW-1:0]     rd_row;
  logic [BW-1:0]     rd_bank_base;

  // ---------------------------------------------------------------------------
  // Handshakes and command decode
  // ---------------------------------------------------------------------------
  assign wr_ready  = !rst;
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_legal  = (int'(wr_bank) < int'(POY)) && (int'(wr_row) < int'(BUFH));

  assign out_valid = (state_q == StHold);
  assign cmd_ready = !out_valid || out_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // BR and BC both read from the bank named by the command.
  assign bank_sel  = (cmd_mode == ModeBr) || (cmd_mode == ModeBc);

  always_comb begin
    cmd_legal = 1'b1;
    if (int'(cmd_row) >= int'(BUFH)) begin
      cmd_legal = 1'b0;
    end
    if (bank_sel && (int'(cmd_bank) >= int'(POY))) begin
      cmd_legal = 1'b0;
    end
    if ((cmd_mode == ModeRp) && (int'(cmd_col) >= int'(BUFW))) begin
      cmd_legal = 1'b0;
    end
  end

  // Clamp read indices on illegal commands so the array is never indexed out of range;
  // the result is discarded in that case anyway.
  assign rd_row       = cmd_legal ? cmd_row : '0;
  assign rd_bank_base = cmd_legal ? cmd_bank : '0;

  // ---------------------------------------------------------------------------
  // Result formation: start from the held output and overwrite selected words.
  // Reading mem_q here returns pre-write contents on a same-cycle write.
  // ---------------------------------------------------------------------------
  always_comb begin
    res_data = out_data_q;
    res_mask = '0;
    for (int i = 0; i < int'(POY); i++) begin
      logic [BW-1:0]   src_bank;
      logic [RowW-1:0] src_row;
      src_bank = bank_sel ? rd_bank_base : BW'(i);
      src_row  = mem_q[src_bank][rd_row];
      for (int k = 0; k < int'(BUFW); k++) begin
        logic upd;
        upd = 1'b0;
        unique case (cmd_mode)
          ModeRr:  upd = 1'b1;
          ModeBr:  upd = (cmd_bank == BW'(i));
          ModeRp:  upd = (cmd_col == CW'(k));
          ModeBc:  upd = 1'b1;
          default: upd = 1'b0;
        endcase
        res_mask[i*BUFW+k] = upd;
        if (upd) begin
          res_data[(i*BUFW+k)*DW +: DW] = src_row[k*DW +: DW];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    blkend_d   = 1'b0;
    blk_cnt_d  = blk_cnt_q;
    err_d      = err_q;

    if (out_valid && out_ready) begin
      state_d = StIdle;
    end

    if (cmd_fire) begin
      if (cmd_legal) begin
        state_d    = StHold;
        out_data_d = res_data;
        out_mask_d = res_mask;
      end else begin
        // Consumed without a result; output registers keep their contents.
        err_d = 1'b1;
      end
      if (cmd_last) begin
        blkend_d  = 1'b1;
        blk_cnt_d = blk_cnt_q + 16'd1;
      end
    end

    if (wr_fire && !wr_legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      out_data_q <= '0;
      out_mask_q <= '0;
      blkend_q   <= 1'b0;
      blk_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      blkend_q   <= blkend_d;
      blk_cnt_q  <= blk_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && wr_legal) begin
      mem_q[wr_bank][wr_row] <= wr_data;
    end
  end

  assign out_data = out_data_q;
  assign out_mask = out_mask_q;
  assign blkend   = blkend_q;
  assign blk_cnt  = blk_cnt_q;
  assign err      = err_q;

endmodule

// File: doc/data_router_lb.md
Name: data_router_lb

Overview:
- Synthesizable line-buffer router feeding the PE array.
- Stores POY banks x BUFH rows x BUFW words, loaded over a valid/ready write port.
- Serves read commands in four modes: full row, single bank, single pixel column, or broadcast. Results go through a one-stage registered output with backpressure.
- Flags illegal commands and pulses blkend at the end of each command block.

Parameters:
DW, 32, word width in bits
POY, 3, number of banks (output rows)
BUFW, 32, words per buffer row
BUFH, 3, rows per bank
BW, $clog2(POY) (min 1), bank index width
RW, $clog2(BUFH) (min 1), row index width
CW, $clog2(BUFW), column index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accept (constant 1 out of reset)
wr_bank  in  BW  target bank
wr_row  in  RW  target row
wr_data  in  BUFW*DW  full row; word k = bits [k*DW +: DW]
cmd_valid  in  1  command request
cmd_ready  out  1  command accept
cmd_mode  in  2  00 RR, 01 BR, 10 RP, 11 BC
cmd_bank  in  BW  bank select (BR, BC)
cmd_row  in  RW  row select
cmd_col  in  CW  column select (RP)
cmd_last  in  1  last command of block
out_data  out  POY*BUFW*DW  bank i word k = bits [(i*BUFW+k)*DW +: DW]
out_mask  out  POY*BUFW  1 = word updated by current result
out_valid  out  1  result valid
out_ready  in  1  downstream accept
blkend  out  1  one-cycle end-of-block pulse
blk_cnt  out  16  completed blocks, wraps at 2^16
err  out  1  sticky illegal-command flag

Behaviour:
- Reset: out_data=0, out_mask=0, out_valid=0, blkend=0, blk_cnt=0, err=0, wr_ready=0 during reset and 1 afterwards. Buffer contents are not reset.
- Write: on wr_valid&&wr_ready, the whole row [wr_bank][wr_row] <= wr_data at clk. A write with wr_bank>=POY or wr_row>=BUFH is dropped and sets err.
- cmd_ready = !out_valid || out_ready. A command is accepted on cmd_valid&&cmd_ready.
- Latency: a command accepted at edge N produces out_valid=1 after edge N (available in cycle N+1). Throughput is one command per cycle while out_ready=1.
- out_valid holds while out_ready=0. out_data and out_mask are stable while out_valid&&!out_ready.
- Read/write on the same row in the same cycle: the read returns the pre-write contents.
- Modes (only masked words change; all other out_data words hold their previous values):
  - RR: every bank i, all words <= buf[i][cmd_row]; mask all ones.
  - BR: bank cmd_bank, all words <= buf[cmd_bank][cmd_row]; mask that bank's BUFW bits only.
  - RP: every bank i, word cmd_col <= buf[i][cmd_row][cmd_col]; mask one bit per bank.
  - BC: every bank i, all words <= buf[cmd_bank][cmd_row]; mask all ones.
- Illegal command: row>=BUFH, or (BR/BC with bank>=POY), or (RP with col>=BUFW).
  - The command is consumed but produces no result: out_valid is not set and out_data is unchanged.
  - err <= 1 and stays set until rst.
- blkend:
  - When an accepted command has cmd_last=1, blkend=1 for exactly one cycle, aligned with that command's first out_valid cycle, even if out_ready stalls that result.
  - blk_cnt increments on the same edge.
  - An illegal command with cmd_last=1 still pulses blkend and increments blk_cnt.
- Internal FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
  - IDLE -> HOLD on accepting a legal command.
  - HOLD -> IDLE on out_ready with no new legal command.
  - HOLD -> HOLD on out_ready plus a new legal command (back-to-back).
- rst mid-stall: all outputs return to reset values on the next edge, and the pending result is discarded.

Test Plan:
- Reset, then write bank0 row1 words k=k, bank1 row1 words k=100+k, bank2 row1 words k=200+k; RR row1 with out_ready=1 -> next cycle out_valid=1, bank2 word5=205, mask all ones.
- With the state above, BR bank1 row1 followed by RP row1 col7 -> second result: bank0 word7=7, bank1 word7=107, bank2 word7=207, bank1 word3=103 (held), mask = bit7 of each bank.
- out_ready=0 for 4 cycles with two commands queued -> cmd_ready=0 after the first is accepted, out_data stable, the second result appears exactly one cycle after out_ready rises.
- Command with row=3 (BUFH=3) and cmd_last=1 -> err=1 sticky, no out_valid, blkend pulses once, blk_cnt=1.
- Write to bank0 row2 with new data and RR row2 issued in the same cycle -> result shows the old bank0 row2 data; a repeat RR shows the new data.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, err=0, blk_cnt=0.
